// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receiver: FSM states, oversampling
// ratio, sample point and frame width.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned OVERSAMPLE      = 16;
  localparam int unsigned SAMPLE_TICK     = 8;
  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned TICK_W          = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W           = $clog2(FRAME_DATA_BITS);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so reset never looks like a start bit.
module spart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spart_rx.sv
// SPART 8N1 receiver with 16x oversampling.
// Define SPART_RX_MAJORITY_EN for 3-sample majority voting at ticks 7/8/9.
module spart_rx
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_enable,
  input  logic       rxd,
  input  logic       read,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_DATA_BITS - 1);
`ifdef SPART_RX_MAJORITY_EN
  localparam logic [TICK_W-1:0] EARLY_TICK  = TICK_W'(SAMPLE_TICK - 1);
  localparam logic [TICK_W-1:0] MID_TICK    = TICK_W'(SAMPLE_TICK);
  localparam logic [TICK_W-1:0] DECIDE_TICK = TICK_W'(SAMPLE_TICK + 1);
`else
  localparam logic [TICK_W-1:0] DECIDE_TICK = TICK_W'(SAMPLE_TICK);
`endif

  rx_state_t                    state;
  logic [TICK_W-1:0]            tick;
  logic [BIT_W-1:0]             bitn;
  logic [FRAME_DATA_BITS-1:0]   shreg;
  logic                         rxs;
  logic                         decide;
  logic                         bit_val;
  logic                         load;

  spart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

`ifdef SPART_RX_MAJORITY_EN
  logic s_early;
  logic s_mid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (rx_enable) begin
      if (tick == EARLY_TICK) s_early <= rxs;
      if (tick == MID_TICK)   s_mid   <= rxs;
    end
  end

  always_comb begin
    bit_val = maj3(s_early, s_mid, rxs);
  end
`else
  always_comb begin
    bit_val = rxs;
  end
`endif

  always_comb begin
    decide = 1'b0;
    load   = 1'b0;
    decide = rx_enable && (tick == DECIDE_TICK);
    load   = decide && (state == STOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tick        <= '0;
      bitn        <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (rx_enable) begin
        unique case (state)
          IDLE: begin
            // The detecting tick is tick 0 of the start bit, so the counter
            // leaves IDLE already at 1; keeps the stop sample at T0+152.
            if (!rxs) begin
              state <= START;
              tick  <= tick + 1'b1;
            end
          end
          START: begin
            tick <= tick + 1'b1;
            if (decide && bit_val) begin
              state <= IDLE;
              tick  <= '0;
            end else if (tick == TICK_LAST) begin
              state <= DATA;
              bitn  <= '0;
            end
          end
          DATA: begin
            tick <= tick + 1'b1;
            if (decide) shreg[bitn] <= bit_val;
            if (tick == TICK_LAST) begin
              if (bitn == BIT_LAST) state <= STOP;
              else                  bitn  <= bitn + 1'b1;
            end
          end
          STOP: begin
            tick <= tick + 1'b1;
            if (decide) begin
              state <= IDLE;
              tick  <= '0;
            end
          end
        endcase
      end

      // A load coinciding with a read wins; the read only cancels overrun.
      if (load) begin
        rx_data     <= shreg;
        rda         <= 1'b1;
        framing_err <= ~bit_val;
        overrun     <= rda & ~read;
      end else if (read && rda) begin
        rda         <= 1'b0;
        framing_err <= 1'b0;
        overrun     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Directed self-checking bench for spart_rx (default or majority build).
`timescale 1ns/1ps
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_enable = 1'b0;
  logic       rxd;
  logic       read;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int unsigned div = 0;

`ifdef SPART_RX_MAJORITY_EN
  localparam int unsigned DECIDE_OFS = 154;
  localparam logic [7:0]  SPIKE_EXP  = 8'h0F;
`else
  localparam int unsigned DECIDE_OFS = 153;
  localparam logic [7:0]  SPIKE_EXP  = 8'h0B;
`endif

  spart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rx_enable   (rx_enable),
    .rxd         (rxd),
    .read        (read),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // One-clock rx_enable pulse every 4 clocks.
  always @(negedge clk) begin
    div = (div == 3) ? 0 : div + 1;
    rx_enable = (div == 0);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      do begin
        @(posedge clk);
        g++;
      end while (rx_enable !== 1'b1 && g < 16);
      if (rx_enable !== 1'b1) begin
        checks++; errors++;
        $display("FAIL tick_timeout: rx_enable=%b required 1", rx_enable);
      end
    end
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_frame_spike(input logic [7:0] b, input int k);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == k) begin
        rxd = b[i];  wait_ticks(8);
        rxd = ~b[i]; wait_ticks(1);
        rxd = b[i];  wait_ticks(7);
      end else begin
        send_bit(b[i]);
      end
    end
    send_bit(1'b1);
  endtask

  task automatic do_read();
    @(negedge clk); read = 1'b1;
    @(negedge clk); read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rxd = 1'b1; read = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h required 00", rx_data); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL rst_rda: got %b required 0", rda); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL rst_fe: got %b required 0", framing_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ov: got %b required 0", overrun); end
    rst = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_rx_byte();
    send_frame(8'hA5, 1'b1);
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h required a5", rx_data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL a5_rda: got %b required 1", rda); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL a5_fe: got %b required 0", framing_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL a5_ov: got %b required 0", overrun); end
    do_read();
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL a5_read_rda: got %b required 0", rda); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_read_data: got %h required a5", rx_data); end
  endtask

  task automatic test_false_start();
    rxd = 1'b0;
    wait_ticks(4);
    rxd = 1'b1;
    wait_ticks(200);
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL false_start_rda: got %b required 0", rda); end
  endtask

  task automatic test_framing_break();
    send_frame(8'h3C, 1'b0);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL fe_data: got %h required 3c", rx_data); end
    checks++; if (framing_err !== 1'b1) begin errors++; $display("FAIL fe_flag: got %b required 1", framing_err); end
    do_read();
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL fe_read_clear: got %b required 0", framing_err); end
    wait_ticks(160);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL break_data: got %h required 00", rx_data); end
    checks++; if (framing_err !== 1'b1) begin errors++; $display("FAIL break_fe: got %b required 1", framing_err); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL break_rda: got %b required 1", rda); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL break_ov: got %b required 0", overrun); end
    rxd = 1'b1;
    wait_ticks(200);
    do_read();
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL break_read_rda: got %b required 0", rda); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ov_data: got %h required 22", rx_data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL ov_rda: got %b required 1", rda); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ov_flag: got %b required 1", overrun); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL ov_fe: got %b required 0", framing_err); end
    do_read();
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL ov_read_rda: got %b required 0", rda); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ov_read_ov: got %b required 0", overrun); end
  endtask

  task automatic test_read_on_load();
    logic [7:0] b;
    b = 8'h55;
    send_frame(8'h11, 1'b1);
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL rol_pre_rda: got %b required 1", rda); end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    rxd = 1'b1;
    wait_ticks(DECIDE_OFS - 1 - 144);
    // Next tick edge is 4 clocks away; assert read only for that edge.
    repeat (4) @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL rol_data: got %h required 55", rx_data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL rol_rda: got %b required 1", rda); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rol_ov: got %b required 0", overrun); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL rol_fe: got %b required 0", framing_err); end
    wait_ticks(16);
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h required 00", rx_data); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL mid_rst_rda: got %b required 0", rda); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL mid_rst_fe: got %b required 0", framing_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_ov: got %b required 0", overrun); end
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    wait_ticks(20);
    send_frame(8'h0F, 1'b1);
    checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL post_rst_data: got %h required 0f", rx_data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL post_rst_rda: got %b required 1", rda); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL post_rst_fe: got %b required 0", framing_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL post_rst_ov: got %b required 0", overrun); end
  endtask

  task automatic test_spike();
    do_read();
    wait_ticks(1);
    send_frame_spike(8'h0F, 2);
    checks++; if (rx_data !== SPIKE_EXP) begin errors++; $display("FAIL spike_data: got %h required %h", rx_data, SPIKE_EXP); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL spike_rda: got %b required 1", rda); end
  endtask

  initial begin
    test_reset();
    test_rx_byte();
    test_false_start();
    test_framing_break();
    test_overrun();
    test_read_on_load();
    test_reset_mid_frame();
    test_spike();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
